multicycle_control: RTL

Control unit for the multicycle MIPS core. It consumes the opcode and function fields that the datapath's instruction register presents. It drives every datapath select and write-enable from a Moore state machine plus an ALU decoder. It also captures the ALU overflow flag so that overflowing signed arithmetic never reaches the register file.

---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit and the datapath.
// The master drives the selects; the slave presents IR fields and ALU flags.
interface multicycle_control_if;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Overflow;
   logic       IorD;
   logic       RegDst;
   logic       MemtoReg;
   logic       IRWrite;
   logic       WE3;
   logic       ALUSrcA;
   logic       Branch;
   logic       PCWrite;
   logic       MemWrite;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   modport master (
      input  Op, Funct, Overflow,
      output IorD, RegDst, MemtoReg, IRWrite, WE3,
      output ALUSrcA, Branch, PCWrite, MemWrite,
      output ALUSrcB, PCSrc, ALUControl, State
   );

   modport slave (
      output Op, Funct, Overflow,
      input  IorD, RegDst, MemtoReg, IRWrite, WE3,
      input  ALUSrcA, Branch, PCWrite, MemWrite,
      input  ALUSrcB, PCSrc, ALUControl, State
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control: Moore FSM, ALU decoder and overflow capture
// that keeps overflowing signed arithmetic out of the register file.
module multicycle_control (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BEQ    = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      AOP_NONE  = 2'd0,
      AOP_ADD   = 2'd1,
      AOP_SUB   = 2'd2,
      AOP_FUNCT = 2'd3
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   state_t     state_q;
   logic       ovf_q;
   aluop_t     aluop;
   logic [2:0] fn_ctl;
   logic       fn_ok;
   logic       fn_arith;

   always_comb begin
      fn_ctl   = 3'b010;
      fn_ok    = 1'b0;
      fn_arith = 1'b0;
      unique case (1'b1)
         (bus.Funct == FN_ADD): begin
            fn_ctl   = 3'b010;
            fn_ok    = 1'b1;
            fn_arith = 1'b1;
         end
         (bus.Funct == FN_SUB): begin
            fn_ctl   = 3'b110;
            fn_ok    = 1'b1;
            fn_arith = 1'b1;
         end
         (bus.Funct == FN_AND): begin
            fn_ctl = 3'b000;
            fn_ok  = 1'b1;
         end
         (bus.Funct == FN_OR): begin
            fn_ctl = 3'b001;
            fn_ok  = 1'b1;
         end
         (bus.Funct == FN_SLT): begin
            fn_ctl = 3'b111;
            fn_ok  = 1'b1;
         end
         default: ;
      endcase
   end

   // Only signed add/sub can overflow; logical ops clear any stale flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            FETCH:  state_q <= DECODE;
            DECODE: begin
               if (bus.Op == OP_LW || bus.Op == OP_SW)
                  state_q <= MEMADR;
               else if (bus.Op == OP_RTYPE)
                  state_q <= EXEC;
               else if (bus.Op == OP_BEQ)
                  state_q <= BEQ;
               else if (bus.Op == OP_ADDI)
                  state_q <= ADDIEX;
               else if (bus.Op == OP_J)
                  state_q <= JUMP;
               else
                  state_q <= FETCH;
            end
            MEMADR: begin
               if (bus.Op == OP_SW)
                  state_q <= MEMWR;
               else
                  state_q <= MEMRD;
            end
            MEMRD:  state_q <= MEMWB;
            EXEC: begin
               state_q <= ALUWB;
               ovf_q   <= fn_arith ? bus.Overflow : 1'b0;
            end
            ADDIEX: begin
               state_q <= ADDIWB;
               ovf_q   <= bus.Overflow;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   always_comb begin
      bus.IorD     = 1'b0;
      bus.RegDst   = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.WE3      = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.Branch   = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.PCSrc    = 2'b00;
      aluop        = AOP_NONE;
      case (state_q)
         FETCH: begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            bus.ALUSrcB = 2'b01;
            aluop       = AOP_ADD;
         end
         DECODE: begin
            bus.ALUSrcB = 2'b11;
            aluop       = AOP_ADD;
         end
         MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            aluop       = AOP_ADD;
         end
         MEMRD: bus.IorD = 1'b1;
         MEMWB: begin
            bus.WE3      = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         MEMWR: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
         end
         EXEC: begin
            bus.ALUSrcA = 1'b1;
            aluop       = AOP_FUNCT;
         end
         ALUWB: begin
            bus.RegDst = 1'b1;
            bus.WE3    = !ovf_q && fn_ok;
         end
         BEQ: begin
            bus.ALUSrcA = 1'b1;
            bus.Branch  = 1'b1;
            bus.PCSrc   = 2'b01;
            aluop       = AOP_SUB;
         end
         ADDIEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            aluop       = AOP_ADD;
         end
         ADDIWB: bus.WE3 = !ovf_q;
         JUMP: begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = 2'b10;
         end
         default: ;
      endcase
      if (reset) begin
         bus.PCWrite  = 1'b0;
         bus.IRWrite  = 1'b0;
         bus.WE3      = 1'b0;
         bus.MemWrite = 1'b0;
         bus.Branch   = 1'b0;
      end
   end

   always_comb begin
      case (aluop)
         AOP_ADD:   bus.ALUControl = 3'b010;
         AOP_SUB:   bus.ALUControl = 3'b110;
         AOP_FUNCT: bus.ALUControl = fn_ctl;
         default:   bus.ALUControl = 3'b000;
      endcase
   end

   assign bus.State = state_q;

endmodule
